// File: rtl/uart_rx.sv
// uart_rx: UART receiver with 2-flop input sync, optional even parity, valid/ready output.
// Define UART_RX_BREAK_DET_EN to add the rx_break output and suppress delivery of break frames.
module uart_rx #(
    parameter int    clk_rate = 50_000_000,
    parameter int    Baud     = 115200,
    parameter int    Word_len = 8,
    parameter string PARITY   = "even"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Uart_rx,
    output logic [Word_len-1:0] rx_data,
    output logic                rx_data_valid,
    input  logic                rx_data_ready,
    output logic                rx_parity_err,
    output logic                rx_frame_err,
`ifdef UART_RX_BREAK_DET_EN
    output logic                rx_break,
`endif
    output logic                rx_overrun
);

    localparam int BaudDiv = clk_rate / Baud;
    localparam int HalfDiv = BaudDiv / 2;
    localparam int CW      = $clog2(BaudDiv);
    localparam int BW      = $clog2(Word_len + 1);
    localparam bit HasPar  = (PARITY != "none");

    localparam logic [CW-1:0] BaudLast = CW'(BaudDiv - 1);
    localparam logic [CW-1:0] HalfLast = CW'(HalfDiv - 1);
    localparam logic [BW-1:0] BitLast  = BW'(Word_len - 1);

    typedef enum logic [2:0] {Idle, Start, Data, Parity, Stop} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [Word_len-1:0] shift_q, shift_d;
    logic                perr_q, perr_d;
    logic                s1_q, s2_q, prev_q;
    logic                fall;
    logic                stop_samp;

    logic [Word_len-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic                pe_q, pe_d;
    logic                fe_q, fe_d;
    logic                ovr_q, ovr_d;
`ifdef UART_RX_BREAK_DET_EN
    logic                ones_q, ones_d;
    logic                hold_q, hold_d;
    logic                brk_q, brk_d;
`endif

    assign fall      = prev_q & ~s2_q;
    assign stop_samp = (state_q == Stop) && (cnt_q == BaudLast);

    // Synchronize the async line and keep the previous value for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= Uart_rx;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    // FSM state, bit timing counters and shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= Idle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            ones_q  <= 1'b0;
            hold_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
`ifdef UART_RX_BREAK_DET_EN
            ones_q  <= ones_d;
            hold_q  <= hold_d;
`endif
        end
    end

    // Next state: sample each bit at its middle, count without wrapping inside a frame.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        perr_d  = perr_q;
`ifdef UART_RX_BREAK_DET_EN
        ones_d  = ones_q;
        hold_d  = hold_q;
`endif
        unique case (state_q)
            Idle: begin
                cnt_d = '0;
`ifdef UART_RX_BREAK_DET_EN
                if (hold_q) begin
                    if (s2_q) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == BaudLast) begin
                            cnt_d  = '0;
                            hold_d = 1'b0;
                        end
                    end
                end else
`endif
                if (fall) state_d = Start;
            end
            Start: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == HalfLast) begin
                    cnt_d = '0;
                    if (s2_q) begin
                        state_d = Idle;
                    end else begin
                        state_d = Data;
                        bit_d   = '0;
                        perr_d  = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        ones_d  = 1'b0;
`endif
                    end
                end
            end
            Data: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BaudLast) begin
                    cnt_d   = '0;
                    shift_d = {s2_q, shift_q[Word_len-1:1]};
                    bit_d   = bit_q + 1'b1;
`ifdef UART_RX_BREAK_DET_EN
                    ones_d  = ones_q | s2_q;
`endif
                    if (bit_q == BitLast) state_d = HasPar ? Parity : Stop;
                end
            end
            Parity: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BaudLast) begin
                    cnt_d   = '0;
                    perr_d  = HasPar && (s2_q != ^shift_q);
`ifdef UART_RX_BREAK_DET_EN
                    ones_d  = ones_q | s2_q;
`endif
                    state_d = Stop;
                end
            end
            Stop: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BaudLast) begin
                    cnt_d   = '0;
                    state_d = Idle;
`ifdef UART_RX_BREAK_DET_EN
                    if (!ones_q && !s2_q) hold_d = 1'b1;
`endif
                end
            end
            default: state_d = Idle;
        endcase
    end

    // Outputs: deliver at the stop sample if the slot is free, else flag overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        pe_d    = pe_q;
        fe_d    = fe_q;
        ovr_d   = 1'b0;
`ifdef UART_RX_BREAK_DET_EN
        brk_d   = 1'b0;
`endif
        if (valid_q && rx_data_ready) valid_d = 1'b0;
        if (stop_samp) begin
`ifdef UART_RX_BREAK_DET_EN
            if (!ones_q && !s2_q) begin
                brk_d = 1'b1;
            end else
`endif
            if (!valid_q || rx_data_ready) begin
                data_d  = shift_q;
                pe_d    = perr_q;
                fe_d    = ~s2_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Registered output stream and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            pe_q    <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            brk_q   <= 1'b0;
`endif
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            pe_q    <= pe_d;
            fe_q    <= fe_d;
            ovr_q   <= ovr_d;
`ifdef UART_RX_BREAK_DET_EN
            brk_q   <= brk_d;
`endif
        end
    end

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign rx_parity_err = pe_q;
    assign rx_frame_err  = fe_q;
    assign rx_overrun    = ovr_q;
`ifdef UART_RX_BREAK_DET_EN
    assign rx_break      = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a frame-level reference model.
// Build with UART_RX_BREAK_DET_EN to also exercise break detection.
module tb_uart_rx;

    localparam int BD = 50_000_000 / 115200;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       Uart_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready = 1'b1;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;
`ifdef UART_RX_BREAK_DET_EN
    logic       rx_break;
`endif

    uart_rx dut (
        .clk          (clk),
        .rst          (rst),
        .Uart_rx      (Uart_rx),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .rx_data_ready(rx_data_ready),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
`ifdef UART_RX_BREAK_DET_EN
        .rx_break     (rx_break),
`endif
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int t0 = 0;
    int rise_cyc = 0;
    int vcnt = 0;
    int ocnt = 0;
    int bcnt = 0;
    int rd = 0;
    logic vld_prev = 1'b0;
    logic [9:0] q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: accepted words, valid cycles, first rise, pulses.
    always @(negedge clk) begin
        if (rx_data_valid && rx_data_ready)
            q.push_back({rx_parity_err, rx_frame_err, rx_data});
        if (rx_data_valid && !vld_prev) rise_cyc = cyc;
        vld_prev = rx_data_valid;
        if (rx_data_valid) vcnt++;
        if (rx_overrun) ocnt++;
`ifdef UART_RX_BREAK_DET_EN
        if (rx_break) bcnt++;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bitt(input logic b);
        Uart_rx = b;
        repeat (BD) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
        @(posedge clk);
        #1;
        t0 = cyc;
        bitt(1'b0);
        for (int i = 0; i < 8; i++) bitt(d[i]);
        bitt(pb);
        bitt(sb);
        Uart_rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
    endtask

    // Reference: word as sent, even-parity mismatch, stop bit 0 means frame error.
    task automatic rx_expect(input string tag, input logic [7:0] d,
                             input logic pb, input logic sb);
        int w;
        w = 0;
        while (q.size() <= rd && w < 1000) begin
            @(posedge clk);
            w++;
        end
        if (q.size() <= rd) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({tag, "_data"}, {24'd0, q[rd][7:0]}, {24'd0, d});
            chk({tag, "_perr"}, {31'd0, q[rd][9]}, {31'd0, pb != ^d});
            chk({tag, "_ferr"}, {31'd0, q[rd][8]}, {31'd0, ~sb});
            rd++;
        end
    endtask

    initial begin
        int v0, o0, d;
        logic [7:0] rd8;
        logic pb, sb;

        repeat (5) @(posedge clk);
        #1;
        chk("rst_data", {24'd0, rx_data}, 32'd0);
        chk("rst_valid", {31'd0, rx_data_valid}, 32'd0);
        chk("rst_perr", {31'd0, rx_parity_err}, 32'd0);
        chk("rst_ferr", {31'd0, rx_frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, rx_overrun}, 32'd0);
        rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        v0 = vcnt;
        send_frame(8'hA5, 1'b0, 1'b1);
        rx_expect("a5", 8'hA5, 1'b0, 1'b1);
        chk("a5_vcycles", vcnt - v0, 32'd1);
        d = rise_cyc - t0 - (BD * 21) / 2;
        chk("a5_latency", {31'd0, (d >= 0 && d <= 6)}, 32'd1);

        send_frame(8'h01, 1'b0, 1'b1);
        rx_expect("p01", 8'h01, 1'b0, 1'b1);

        send_frame(8'h3C, 1'b0, 1'b0);
        rx_expect("f3c", 8'h3C, 1'b0, 1'b0);
        send_frame(8'h55, 1'b0, 1'b1);
        rx_expect("n55", 8'h55, 1'b0, 1'b1);

        rx_data_ready = 1'b0;
        o0 = ocnt;
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        chk("ovr_hold", {24'd0, rx_data}, 32'h11);
        chk("ovr_valid", {31'd0, rx_data_valid}, 32'd1);
        chk("ovr_pulses", ocnt - o0, 32'd1);
        @(negedge clk);
        rx_data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rx_expect("ovr_take", 8'h11, 1'b0, 1'b1);
        chk("ovr_drop", {31'd0, rx_data_valid}, 32'd0);

        v0 = vcnt;
        Uart_rx = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        Uart_rx = 1'b1;
        repeat (BD * 2) @(posedge clk);
        #1;
        chk("glitch_nv", vcnt - v0, 32'd0);
        chk("glitch_q", q.size(), rd);

        bitt(1'b0);
        bitt(1'b1);
        bitt(1'b0);
        bitt(1'b1);
        rst = 1'b0;
        #1;
        chk("mrst_data", {24'd0, rx_data}, 32'd0);
        chk("mrst_valid", {31'd0, rx_data_valid}, 32'd0);
        Uart_rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (BD) @(posedge clk);
        #1;
        chk("mrst_noq", q.size(), rd);
        send_frame(8'h7E, 1'b0, 1'b1);
        rx_expect("r7e", 8'h7E, 1'b0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            rd8 = 8'($urandom_range(0, 255));
            pb = 1'($urandom_range(0, 1));
            sb = ($urandom_range(0, 3) != 0);
            if (!sb && rd8 == 8'h00) rd8 = 8'h5A;
            send_frame(rd8, pb, sb);
            rx_expect($sformatf("rnd%0d", i), rd8, pb, sb);
        end

`ifdef UART_RX_BREAK_DET_EN
        v0 = vcnt;
        Uart_rx = 1'b0;
        repeat (BD * 12) @(posedge clk);
        #1;
        Uart_rx = 1'b1;
        repeat (BD * 2) @(posedge clk);
        #1;
        chk("brk_pulse", bcnt, 32'd1);
        chk("brk_nv", vcnt - v0, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
